// File: rtl/fib_seq_capture.sv
// Decimating capture of the Fibonacci term stream into a FIFO.
// Capture ends at the first 32-bit wrap, on stop, and drains before idling.
module fib_seq_capture #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 8,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       seq_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [7:0]        interval_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_data_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic              busy_o,
  output logic              wrap_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0] term_idx;
  logic [31:0]      prev_seq;
  logic [7:0]       interval;
  logic [7:0]       phase;

  logic [31:0]      mem_data [DEPTH];
  logic [IDX_W-1:0] mem_idx  [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  logic empty, full, one_left;
  logic pop, push, drop;
  logic wrap_det;
  logic accept_start, capture, wrap_set, advance;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign one_left = ((wr_ptr - rd_ptr) == (AW+1)'(1));

  assign wrap_det = (term_idx >= IDX_W'(2)) && (seq_i < prev_seq);

  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign pop  = !empty && out_ready_i;
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  always_comb begin
    state_nx     = state;
    accept_start = 1'b0;
    capture      = 1'b0;
    wrap_set     = 1'b0;
    advance      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          accept_start = 1'b1;
          state_nx     = CAPTURE;
        end
      end
      CAPTURE: begin
        if (wrap_det) begin
          wrap_set = 1'b1;
          state_nx = DONE;
        end else if (stop_i) begin
          state_nx = DONE;
        end else begin
          advance = 1'b1;
          capture = (phase == 8'd0);
        end
      end
      DONE: begin
        if (empty || (one_left && pop))
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      term_idx <= '0;
      prev_seq <= '0;
      interval <= '0;
      phase    <= '0;
      wrap_o   <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      state    <= state_nx;
      prev_seq <= seq_i;
      if (term_idx != '1)
        term_idx <= term_idx + 1'b1;
      if (accept_start) begin
        interval   <= interval_i;
        phase      <= '0;
        wrap_o     <= 1'b0;
        drop_cnt_o <= '0;
      end else begin
        if (advance)
          phase <= (phase == 8'd0) ? interval : phase - 1'b1;
        if (wrap_set)
          wrap_o <= 1'b1;
        if (drop && (drop_cnt_o != '1))
          drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[AW-1:0]] <= seq_i;
      mem_idx[wr_ptr[AW-1:0]]  <= term_idx;
    end
  end

  assign out_valid_o = !empty;
  assign out_data_o  = empty ? '0 : mem_data[rd_ptr[AW-1:0]];
  assign out_idx_o   = empty ? '0 : mem_idx[rd_ptr[AW-1:0]];
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_fib_seq_capture.sv
// Bench for fib_seq_capture: models the generator and scoreboards the
// trace port against a software Fibonacci reference.
module tb_fib_seq_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] seq_i;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [7:0]  interval_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic [7:0]  out_idx_o;
  logic        busy_o;
  logic        wrap_o;
  logic [15:0] drop_cnt_o;

  fib_seq_capture #(.DEPTH(4), .IDX_W(8), .DROP_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .seq_i       (seq_i),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .interval_i  (interval_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_idx_o   (out_idx_o),
    .busy_o      (busy_o),
    .wrap_o      (wrap_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk = ~clk;

  logic [31:0] fa, fb;
  int          tb_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fa     <= 32'd0;
      fb     <= 32'd1;
      tb_idx <= 0;
    end else begin
      fa     <= fb;
      fb     <= fa + fb;
      tb_idx <= tb_idx + 1;
    end
  end
  assign seq_i = fa;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    int          start_idx;
    int          interval;
    int          stop_idx;
    int          end_idx;
    int          exp_n;
    bit          exp_wrap;
    logic [31:0] exp_last;
  } vec_t;

  ent_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          rx_cnt = 0;
  logic [31:0] last_data = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fib(int n);
    logic [31:0] a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always begin
    @(negedge clk);
    #1;
    if (!reset && out_valid_o && out_ready_i) begin
      rx_cnt++;
      last_data = out_data_o;
      if (q.size() == 0) begin
        chk("unexpected_entry", {24'd0, out_idx_o, out_data_o}, 64'd0);
      end else begin
        ent_t e;
        e = q.pop_front();
        chk("out_idx", 64'(out_idx_o), 64'(e.idx));
        chk("out_data", 64'(out_data_o), 64'(e.data));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start_i = 1'b0;
    stop_i = 1'b0;
    out_ready_i = 1'b0;
    #1;
    chk("rst_busy_valid_wrap", {busy_o, out_valid_o, wrap_o}, 0);
    chk("rst_drop", 64'(drop_cnt_o), 0);
    chk("rst_head", {out_idx_o, out_data_o}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q.delete();
    rx_cnt = 0;
  endtask

  task automatic wait_idx(int n);
    for (int c = 0; c < 300; c++) begin
      if (tb_idx == n) return;
      @(negedge clk);
    end
    chk("wait_idx_timeout", 0, 1);
  endtask

  task automatic pulse_start(int n, int iv);
    wait_idx(n);
    start_i = 1'b1;
    interval_i = 8'(iv);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic pulse_stop(int n);
    wait_idx(n);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (!busy_o) return;
    end
    chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic push_exp(int idx);
    ent_t e;
    e.idx = idx;
    e.data = fib(idx);
    q.push_back(e);
  endtask

  vec_t vecs[3];

  initial begin
    vecs[0] = '{3, 0, 7, 7, 3, 0, 32'd8};
    vecs[1] = '{0, 2, 11, 11, 4, 0, 32'd55};
    vecs[2] = '{0, 0, -1, 48, 47, 1, 32'd2971215073};

    for (int v = 0; v < 3; v++) begin
      do_reset();
      for (int i = vecs[v].start_idx + 1; i < vecs[v].end_idx; i++)
        if ((i - vecs[v].start_idx - 1) % (vecs[v].interval + 1) == 0)
          push_exp(i);
      out_ready_i = 1'b1;
      pulse_start(vecs[v].start_idx, vecs[v].interval);
      if (vecs[v].stop_idx >= 0)
        pulse_stop(vecs[v].stop_idx);
      wait_idle();
      chk("rx_count", 64'(rx_cnt), 64'(vecs[v].exp_n));
      chk("queue_left", 64'(q.size()), 0);
      chk("last_data", 64'(last_data), 64'(vecs[v].exp_last));
      chk("wrap", 64'(wrap_o), 64'(vecs[v].exp_wrap));
      chk("drops", 64'(drop_cnt_o), 0);
    end

    // Backpressure: FIFO of 4 fills, six later samples drop
    do_reset();
    pulse_start(0, 0);
    pulse_stop(11);
    wait_idx(13);
    chk("bp_busy", 64'(busy_o), 1);
    chk("bp_drops", 64'(drop_cnt_o), 6);
    chk("bp_head", {out_valid_o, out_idx_o, out_data_o}, {1'b1, 8'd1, 32'd1});
    repeat (2) @(negedge clk);
    chk("bp_head_hold", {out_valid_o, out_idx_o, out_data_o}, {1'b1, 8'd1, 32'd1});
    for (int i = 1; i <= 4; i++)
      push_exp(i);
    out_ready_i = 1'b1;
    wait_idle();
    chk("bp_rx_count", 64'(rx_cnt), 4);
    chk("bp_queue_left", 64'(q.size()), 0);

    // Start and stop outside their states are ignored
    do_reset();
    pulse_stop(2);
    #1;
    chk("stop_in_idle", 64'(busy_o), 0);
    pulse_start(3, 0);
    pulse_start(10, 0);
    #1;
    chk("start_in_capture_busy", 64'(busy_o), 1);
    chk("start_in_capture_drops", 64'(drop_cnt_o), 3);
    pulse_stop(12);
    pulse_start(13, 0);
    #1;
    chk("start_in_done_busy", 64'(busy_o), 1);
    chk("start_in_done_drops", 64'(drop_cnt_o), 4);
    for (int i = 4; i <= 7; i++)
      push_exp(i);
    out_ready_i = 1'b1;
    wait_idle();
    chk("ign_rx_count", 64'(rx_cnt), 4);

    // Asynchronous reset mid-capture with two entries buffered
    do_reset();
    pulse_start(0, 0);
    wait_idx(3);
    stop_i = 1'b1;
    #1;
    chk("pre_rst_valid", 64'(out_valid_o), 1);
    reset = 1'b1;
    stop_i = 1'b0;
    #1;
    chk("async_rst_outs", {out_valid_o, busy_o, wrap_o}, 0);
    chk("async_rst_drop", 64'(drop_cnt_o), 0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    rx_cnt = 0;
    push_exp(1);
    push_exp(2);
    out_ready_i = 1'b1;
    pulse_start(0, 0);
    pulse_stop(3);
    wait_idle();
    chk("post_rst_rx_count", 64'(rx_cnt), 2);
    chk("post_rst_queue_left", 64'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
